// File: rtl/shifter_pkg.sv
// shifter_pkg: shared mode constants and FSM state encoding for seq_shifter
package shifter_pkg;
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of data by a fixed STEP bits in the selected mode
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] sll, srl, sra, rol;
    // all four candidate results, then select by mode
    always_comb begin
        sll    = data_i << STEP;
        srl    = data_i >> STEP;
        sra    = WIDTH'($signed(data_i) >>> STEP);
        rol    = {data_i[WIDTH-STEP-1:0], data_i[WIDTH-1 -: STEP]};
        data_o = mode_i == MODE_SLL ? sll :
                 mode_i == MODE_SRL ? srl :
                 mode_i == MODE_ROL ? rol : sra;
    end
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter (SLL/SRL/SRA/ROL) with start/done handshake; SEQ_SHIFTER_FAST_EN adds 4-bit steps
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dout
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d, dout_q, dout_d, step1, stepped;
    logic [SHAMT_W-1:0] cnt_q, cnt_d, dec;
    logic [1:0]         md_q, md_d;

    shift_step #(.WIDTH(WIDTH), .STEP(1)) u_step1 (
        .data_i (data_q),
        .mode_i (md_q),
        .data_o (step1)
    );

`ifdef SEQ_SHIFTER_FAST_EN
    logic [WIDTH-1:0] step4;
    logic             use4;

    shift_step #(.WIDTH(WIDTH), .STEP(4)) u_step4 (
        .data_i (data_q),
        .mode_i (md_q),
        .data_o (step4)
    );

    // take a 4-bit stride while at least four bits remain
    always_comb begin
        use4    = 32'(cnt_q) >= 32'd4;
        stepped = use4 ? step4 : step1;
        dec     = use4 ? SHAMT_W'(4) : SHAMT_W'(1);
    end
`else
    // one bit per cycle
    always_comb begin
        stepped = step1;
        dec     = SHAMT_W'(1);
    end
`endif

    // state and datapath registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            md_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            md_q    <= md_d;
            dout_q  <= dout_d;
        end
    end

    // next state: accept in IDLE/DONE, step in SHIFT, publish result on the last step
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        md_d    = md_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    data_d  = din;
                    cnt_d   = shamt;
                    md_d    = mode;
                    state_d = shamt == '0 ? ST_DONE : ST_SHIFT;
                    dout_d  = shamt == '0 ? din : dout_q;
                end
            end
            ST_SHIFT: begin
                data_d  = stepped;
                cnt_d   = cnt_q - dec;
                state_d = cnt_q == dec ? ST_DONE : ST_SHIFT;
                dout_d  = cnt_q == dec ? stepped : dout_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // handshake outputs decode from the state register alone
    always_comb begin
        ready = state_q == ST_IDLE || state_q == ST_DONE;
        busy  = state_q == ST_SHIFT;
        done  = state_q == ST_DONE;
        dout  = dout_q;
    end
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench for seq_shifter; latency expectations follow SEQ_SHIFTER_FAST_EN
module tb_seq_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] din = '0;
    logic [3:0]  shamt = '0;
    logic        ready, busy, done;
    logic [15:0] dout;

    typedef struct {
        logic [15:0] d;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    seq_shifter #(.WIDTH(16), .SHAMT_W(4)) dut (
        .CLK   (clk),
        .Reset (rst),
        .start (start),
        .mode  (mode),
        .din   (din),
        .shamt (shamt),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [1:0] m, input logic [15:0] d, input int k);
        logic [15:0] r;
        case (m)
            2'b00:   r = d << k;
            2'b01:   r = d >> k;
            2'b10:   r = 16'($signed(d) >>> k);
            default: r = (d << k) | (d >> (16 - k));
        endcase
        return r;
    endfunction

    function automatic int lat_of(input int k);
`ifdef SEQ_SHIFTER_FAST_EN
        return k / 4 + k % 4 + 1;
`else
        return k + 1;
`endif
    endfunction

    task automatic start_op(input logic [1:0] m, input logic [15:0] d, input logic [3:0] k);
        exp_t e;
        mode = m;
        din = d;
        shamt = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.d = model(m, d, int'(k));
        e.lat = lat_of(int'(k));
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int   n = 0;
        while (done !== 1'b1 && n < 40) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy: got %b want 1", name, busy);
            end
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done never rose", name);
            return;
        end
        checks++;
        if (cyc - e.acc + 1 !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc - e.acc + 1, e.lat);
        end
        checks++;
        if (dout !== e.d) begin
            errors++;
            $display("FAIL %s dout: got %h want %h", name, dout, e.d);
        end
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s ready/busy at done: got %b/%b want 1/0", name, ready, busy);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dout, ready, busy, done} !== {16'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset: got dout=%h r/b/d=%b%b%b want 0000 100", dout, ready, busy, done);
        end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_modes();
        start_op(2'b00, 16'h0F0F, 4'd3);
        wait_done("sll");
        idle_cycle();
        start_op(2'b10, 16'h8004, 4'd2);
        wait_done("sra_neg");
        start_op(2'b01, 16'h8004, 4'd2);
        wait_done("srl");
        start_op(2'b11, 16'h8001, 4'd1);
        wait_done("rol_wrap");
        start_op(2'b11, 16'hA5C3, 4'd0);
        wait_done("zero_shift");
        start_op(2'b00, 16'hFFFF, 4'd15);
        wait_done("sll_max");
        start_op(2'b01, 16'hFFFF, 4'd15);
        wait_done("srl_max");
        start_op(2'b10, 16'h8000, 4'd15);
        wait_done("sra_sat");
        start_op(2'b11, 16'h1234, 4'd12);
        wait_done("rol_12");
        start_op(2'b00, 16'h0001, 4'd10);
        wait_done("sll_10");
    endtask

    task automatic test_ignore_start();
        idle_cycle();
        start_op(2'b01, 16'hF0F0, 4'd9);
        start = 1'b1;
        din = 16'h1234;
        mode = 2'b11;
        shamt = 4'd1;
        idle_cycle();
        start = 1'b0;
        wait_done("ignore_start");
    endtask

    task automatic test_back_to_back();
        start_op(2'b00, 16'h0001, 4'd15);
        wait_done("back_to_back");
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) idle_cycle();
            start_op(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
            wait_done("random");
        end
    endtask

    task automatic test_reset_mid();
        start_op(2'b00, 16'hFFFF, 4'd10);
        void'(sb.pop_back());
        idle_cycle();
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        checks++;
        if ({dout, ready, busy, done} !== {16'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid: got dout=%h r/b/d=%b%b%b want 0000 100", dout, ready, busy, done);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid quiet: got done=%b busy=%b want 0/0", done, busy);
            end
            idle_cycle();
        end
        start_op(2'b10, 16'hC000, 4'd5);
        wait_done("after_reset");
    endtask

    initial begin
        test_reset();
        test_modes();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
